// File: rtl/scs8hd_nor4b_qual_pkg.sv
// Shared types and widths for the scs8hd_nor4b detect qualifier.
package scs8hd_nor4b_qual_pkg;

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned EVCNT_W = 8;
  localparam logic [EVCNT_W-1:0] EVCNT_MAX = 8'd255;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    QUAL   = 2'd1,
    ACTIVE = 2'd2,
    REL    = 2'd3
  } state_e;

endpackage

// File: rtl/scs8hd_nor4b_qual_sat_cnt.sv
// Saturating event counter with synchronous clear; clear beats increment.
module scs8hd_nor4b_qual_sat_cnt
  import scs8hd_nor4b_qual_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_clr,
  input  logic               i_inc,
  output logic [EVCNT_W-1:0] o_cnt
);

  logic [EVCNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != EVCNT_MAX)) begin
      r_cnt <= r_cnt + EVCNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/scs8hd_nor4b_qual.sv
// Debounce/qualifier for the raw scs8hd_nor4b detect output, with edge pulses.
// Define SCS8HD_NOR4B_QUAL_EVCNT_EN to include the saturating event counter.
module scs8hd_nor4b_qual
  import scs8hd_nor4b_qual_pkg::*;
#(
  parameter int unsigned QUAL_CYC = 4,
  parameter int unsigned REL_CYC  = 3
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               Y_IN,
  input  logic               EN,
  input  logic               CLR_CNT,
  output logic               Q,
  output logic               RISE,
  output logic               FALL,
  output logic [EVCNT_W-1:0] EVCNT
);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_q;
  logic             r_rise;
  logic             r_fall;

  state_e           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_q_nxt;

  assign w_cnt_inc = r_cnt + CNT_W'(1);

  // State, run counter and registered outputs; reset never produces a FALL.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_q     <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_q     <= w_q_nxt;
      r_rise  <= w_q_nxt & ~r_q;
      r_fall  <= ~w_q_nxt & r_q;
    end
  end

  // Next state; Q is high exactly in ACTIVE and REL.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (!EN) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (Y_IN) begin
            w_state_nxt = QUAL;
            w_cnt_nxt   = CNT_W'(1);
          end else begin
            w_cnt_nxt = '0;
          end
        end
        QUAL: begin
          if (!Y_IN) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else if (w_cnt_inc == CNT_W'(QUAL_CYC)) begin
            w_state_nxt = ACTIVE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        ACTIVE: begin
          if (!Y_IN) begin
            w_state_nxt = REL;
            w_cnt_nxt   = CNT_W'(1);
          end else begin
            w_cnt_nxt = '0;
          end
        end
        REL: begin
          if (Y_IN) begin
            w_state_nxt = ACTIVE;
            w_cnt_nxt   = '0;
          end else if (w_cnt_inc == CNT_W'(REL_CYC)) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
    w_q_nxt = (w_state_nxt == ACTIVE) || (w_state_nxt == REL);
  end

  assign Q    = r_q;
  assign RISE = r_rise;
  assign FALL = r_fall;

`ifdef SCS8HD_NOR4B_QUAL_EVCNT_EN
  scs8hd_nor4b_qual_sat_cnt u_sat_cnt (
    .i_clk (CLK),
    .i_rst (RESET),
    .i_clr (CLR_CNT),
    .i_inc (r_rise),
    .o_cnt (EVCNT)
  );
`else
  logic w_unused_clr;
  assign w_unused_clr = CLR_CNT;
  assign EVCNT        = '0;
`endif

endmodule
